uart_tx_fifo: RTL and testbench

Byte-wide transmit buffer between a byte source (typically `uart_rx` data/valid) and `uart_tx`. It absorbs single-cycle write strobes into a DEPTH-entry circular FIFO. It drains entries one at a time into `uart_tx` using the `uart_tx_en`/`uart_tx_busy` handshake, so bytes arriving while the transmitter is busy are not lost. It removes the unbuffered valid-to-enable path from the loopback top level.

---
 rtl/uart_tx_fifo.sv | 84 ++++++++
 tb/tb_uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte-wide circular FIFO that buffers write strobes and drains them one at a
// time into uart_tx via the uart_tx_en / uart_tx_busy handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          overflow_clr,
  input  logic          uart_tx_busy,
  output logic          uart_tx_en,
  output logic [7:0]    uart_tx_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  logic          pop;
  logic          push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty && !uart_tx_busy;
  // A pop frees a slot in the same cycle, so a write at full is still accepted.
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && !push)    overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      uart_tx_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            uart_tx_data <= mem[rd_ptr];
            uart_tx_en   <= 1'b1;
            state        <= SEND;
          end
        end
        SEND:  state <= ACK;
        ACK:   if (uart_tx_busy)  state <= DRAIN;
        DRAIN: if (!uart_tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a uart_tx model consumes strobes and checks bytes
// against a queue of expected bytes filled as writes are driven.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          overflow_clr;
  logic          busy;
  logic          uart_tx_en;
  logic [7:0]    uart_tx_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .overflow_clr (overflow_clr),
    .uart_tx_busy (busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;
  logic [7:0]  exp_q[$];
  int unsigned busy_len = 5;
  int unsigned remaining = 0;
  logic        hold_busy = 1'b0;
  logic        prev_en = 1'b0;
  int unsigned en_pulses = 0;
  int unsigned peak = 0;

  assign busy = hold_busy | (remaining != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // uart_tx model: busy rises after each strobe and stays up busy_len cycles
  always @(negedge clk) begin
    if (!resetn) begin
      prev_en = 1'b0;
    end else begin
      if (remaining > 0) remaining--;
      if (uart_tx_en) begin
        en_pulses++;
        chk("en_single_cycle", 32'(prev_en), 32'd0);
        chk("en_after_busy_low", remaining, 32'd0);
        if (exp_q.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_en: got data %0h expected no strobe at %0t", uart_tx_data, $time);
        end else begin
          chk("tx_data", 32'(uart_tx_data), 32'(exp_q.pop_front()));
        end
        remaining = busy_len;
      end
      prev_en = uart_tx_en;
      if (32'(count) > peak) peak = 32'(count);
    end
  end

  task automatic wait_drain(input int unsigned max);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy || !empty || uart_tx_en) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < max), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic       acc;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [7:0] d, logic clr, logic acc,
                              int cnt, logic f, logic e, logic o);
    vec_t v;
    v.wr = wr; v.data = d; v.clr = clr; v.acc = acc;
    v.cnt = 5'(cnt); v.full = f; v.empty = e; v.ovf = o;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    int unsigned p0;
    int unsigned n;

    for (int i = 0; i < 16; i++)
      vecs[i] = mk(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1, i + 1, i == 15, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 8'hFF, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 8'hFE, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b1);
    vecs[19] = mk(1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0);

    resetn = 1'b0; wr_en = 1'b0; wr_data = '0; overflow_clr = 1'b0;
    #1;
    chk("rst_en", 32'(uart_tx_en), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(uart_tx_data), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // single byte latency
    wr_en = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41);
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_empty_n", 32'(empty), 32'd0);
    chk("lat_count_n", 32'(count), 32'd1);
    chk("lat_en_n", 32'(uart_tx_en), 32'd0);
    @(negedge clk);
    chk("lat_en_n1", 32'(uart_tx_en), 32'd1);
    chk("lat_data_n1", 32'(uart_tx_data), 32'h41);
    chk("lat_count_n1", 32'(count), 32'd0);
    chk("lat_empty_n1", 32'(empty), 32'd1);
    @(negedge clk);
    chk("lat_en_n2", 32'(uart_tx_en), 32'd0);
    wait_drain(200);

    // burst ordering with a slow transmitter
    busy_len = 100; peak = 0; p0 = en_pulses;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_drain(1000);
    chk("burst_peak", peak, 32'd3);
    chk("burst_pulses", en_pulses - p0, 32'd4);
    busy_len = 5;

    // fill / overflow / clear table with the transmitter held busy
    hold_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].data; overflow_clr = vecs[i].clr;
      if (vecs[i].acc) exp_q.push_back(vecs[i].data);
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(vecs[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end
    overflow_clr = 1'b0;
    // write at full coinciding with the first pop
    hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk);
    wr_en = 1'b0;
    chk("fullpop_count", 32'(count), 32'd16);
    chk("fullpop_full", 32'(full), 32'd1);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_en", 32'(uart_tx_en), 32'd1);
    wait_drain(600);
    chk("fullpop_empty", 32'(empty), 32'd1);

    // push in the pop cycle at count 1
    hold_busy = 1'b1; wr_en = 1'b1; wr_data = 8'h10; exp_q.push_back(8'h10);
    @(negedge clk);
    hold_busy = 1'b0; wr_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk);
    wr_en = 1'b0;
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_en", 32'(uart_tx_en), 32'd1);
    chk("pp_data", 32'(uart_tx_data), 32'h10);
    wait_drain(200);
    chk("pp_count_end", 32'(count), 32'd0);

    // wrap-around with irregular write spacing
    busy_len = 3; p0 = en_pulses;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (full && n < 100) begin @(negedge clk); n++; end
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      @(negedge clk);
      wr_en = 1'b0;
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_drain(2000);
    chk("wrap_pulses", en_pulses - p0, 32'd40);
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // reset while draining with 3 bytes queued
    busy_len = 20; hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC1 + i); exp_q.push_back(8'(8'hC1 + i));
      @(negedge clk);
    end
    wr_en = 1'b0; hold_busy = 1'b0;
    n = 0;
    while (!uart_tx_en && n < 20) begin @(negedge clk); n++; end
    chk("rd_en_seen", 32'(uart_tx_en), 32'd1);
    repeat (5) @(negedge clk);
    chk("rd_count_before", 32'(count), 32'd3);
    resetn = 1'b0; exp_q.delete(); remaining = 0;
    #1;
    chk("rd_en", 32'(uart_tx_en), 32'd0);
    chk("rd_data", 32'(uart_tx_data), 32'd0);
    chk("rd_count", 32'(count), 32'd0);
    chk("rd_empty", 32'(empty), 32'd1);
    chk("rd_full", 32'(full), 32'd0);
    chk("rd_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1; p0 = en_pulses;
    repeat (30) @(negedge clk);
    chk("rd_no_en", en_pulses - p0, 32'd0);
    wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain(200);
    chk("rd_new_pulse", en_pulses - p0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
